// File: rtl/bitarr_pkg.sv
// Shared constants and types for the bit-array write arbiter and its
// round-robin scheduler.
package bitarr_pkg;

  localparam int N_ENTRIES = 12;
  localparam int N_REQ     = 4;
  localparam int IDX_W     = 4;
  localparam int ID_W      = $clog2(N_REQ);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [ID_W-1:0]  id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter: the first valid requester at or
// after ptr (mod N_REQ) wins; nothing is granted while en is low.
module rr_arbiter #(
  parameter int N_REQ = bitarr_pkg::N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  id
);

  always_comb begin
    int   j;
    logic found;
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    grant = '0;
    id    = '0;
    found = 1'b0;
    j     = 0;
    if (en) begin
      for (int k = 0; k < N_REQ; k++) begin
        // ptr is always < N_REQ, so this stays in range for any N_REQ.
        j = (int'(ptr) + k) % N_REQ;
        if (!found && valid[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          id       = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/bitarr_write_arbiter.sv
// Shared single-bit register array with one round-robin scheduled write per
// cycle; the accepted write becomes visible on arr_out one clock later.
module bitarr_write_arbiter
  import bitarr_pkg::*;
#(
  parameter int N_ENTRIES = bitarr_pkg::N_ENTRIES,
  parameter int N_REQ     = bitarr_pkg::N_REQ,
  parameter int IDX_W     = bitarr_pkg::IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*IDX_W-1:0]   req_idx,
  input  logic [N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     clr,
  output logic [N_ENTRIES-1:0]     arr_out,
  output logic                     wr_valid,
  output logic [$clog2(N_REQ)-1:0] wr_id,
  output logic                     err
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      gnt_id;
  logic [N_REQ-1:0]     grant;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_data;
  logic                 xfer;
  logic                 oob;
  logic [N_ENTRIES-1:0] arr_q;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .valid (req_valid),
    .ptr   (ptr),
    .en    (!rst && !clr),
    .grant (grant),
    .id    (gnt_id)
  );

  assign req_ready = grant;
  assign xfer      = |grant;
  assign sel_idx   = req_idx[int'(gnt_id)*IDX_W +: IDX_W];
  assign sel_data  = req_data[gnt_id];
  assign oob       = 32'(sel_idx) >= N_ENTRIES;

  // Entry k is presented MSB-first: entry 0 lands on the top bit.
  always_comb begin
    arr_out = '0;
    for (int k = 0; k < N_ENTRIES; k++) begin
      arr_out[N_ENTRIES-1-k] = arr_q[k];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arr_q    <= '0;
      ptr      <= '0;
      wr_valid <= 1'b0;
      wr_id    <= '0;
      err      <= 1'b0;
    end else if (clr) begin
      arr_q    <= '0;
      wr_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_valid <= xfer;
      err      <= xfer && oob;
      if (xfer) begin
        wr_id <= gnt_id;
        ptr   <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
      end
      for (int k = 0; k < N_ENTRIES; k++) begin
        if (xfer && !oob && sel_idx == IDX_W'(k)) begin
          arr_q[k] <= sel_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitarr_write_arbiter.sv
// Directed scenarios plus randomized traffic for bitarr_write_arbiter, checked
// against a behavioural model of the shared array and round-robin schedule.
module tb_bitarr_write_arbiter;
  import bitarr_pkg::*;

  localparam int NE  = N_ENTRIES;
  localparam int NR  = N_REQ;
  localparam int IW  = IDX_W;
  localparam int IDW = $clog2(NR);

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic [NR-1:0]     req_valid;
  logic [NR*IW-1:0]  req_idx;
  logic [NR-1:0]     req_data;
  logic [NR-1:0]     req_ready;
  logic [NE-1:0]     arr_out;
  logic              wr_valid;
  logic [IDW-1:0]    wr_id;
  logic              err;

  int total = 0;
  int bad   = 0;

  // Behavioural model
  bit m_arr [NE];
  int m_ptr;
  bit m_wv;
  int m_wid;
  bit m_err;

  // Random-traffic requester state
  bit pv [NR];
  int pidx [NR];
  bit pd [NR];

  bitarr_write_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_idx   (req_idx),
    .req_data  (req_data),
    .req_ready (req_ready),
    .clr       (clr),
    .arr_out   (arr_out),
    .wr_valid  (wr_valid),
    .wr_id     (wr_id),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NE-1:0] exp_arr();
    logic [NE-1:0] v;
    v = '0;
    for (int k = 0; k < NE; k++) v[NE-1-k] = m_arr[k];
    return v;
  endfunction

  // Rule: first valid requester scanning from ptr upward, wrapping.
  function automatic int exp_grant();
    if (rst || clr) return -1;
    for (int k = 0; k < NR; k++) begin
      if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset();
    foreach (m_arr[k]) m_arr[k] = 1'b0;
    m_ptr = 0;
    m_wv  = 1'b0;
    m_wid = 0;
    m_err = 1'b0;
  endtask

  task automatic set_req(input int i, input bit v, input int idx, input bit d);
    req_valid[i]          = v;
    req_idx[i*IW +: IW]   = IW'(idx);
    req_data[i]           = d;
  endtask

  // One clock: check the grant mid-cycle, advance the model at the edge,
  // then check registered outputs just after it. Returns the granted id or -1.
  task automatic step(output int g);
    int idx;
    @(negedge clk);
    g = exp_grant();
    check("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    @(posedge clk);
    if (clr) begin
      foreach (m_arr[k]) m_arr[k] = 1'b0;
      m_wv  = 1'b0;
      m_err = 1'b0;
    end else if (g >= 0) begin
      idx   = int'(req_idx[g*IW +: IW]);
      m_wv  = 1'b1;
      m_wid = g;
      m_err = (idx >= NE);
      if (idx < NE) m_arr[idx] = req_data[g];
      m_ptr = (g + 1) % NR;
    end else begin
      m_wv  = 1'b0;
      m_err = 1'b0;
    end
    #1;
    check("arr_out", 32'(arr_out), 32'(exp_arr()));
    check("wr_valid", 32'(wr_valid), 32'(m_wv));
    check("err", 32'(err), 32'(m_err));
    if (m_wv) check("wr_id", 32'(wr_id), 32'(m_wid));
  endtask

  initial begin
    int g;

    // Reset holds everything at zero even with all requesters valid.
    rst = 1'b1;
    clr = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, i, 1'b1);
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_arr", 32'(arr_out), 32'd0);
    @(posedge clk);
    #1;
    check("rst_ready_edge", 32'(req_ready), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    model_reset();

    // All four valid, idx=i, data=1: grants 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      step(g);
      check("rr_order", 32'(g), 32'(k % NR));
      if (k == 3) check("all_four_arr", 32'(arr_out), 32'h00000F00);
    end

    // clr with requests pending: nothing accepted, array cleared, ptr held at 1.
    clr = 1'b1;
    step(g);
    check("clr_arr", 32'(arr_out), 32'd0);
    clr = 1'b0;
    step(g);
    check("post_clr_grant", 32'(g), 32'd1);
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 0, 1'b0);
    clr = 1'b1;
    step(g);
    clr = 1'b0;

    // Single writer: requester 2 sets then clears entry 3.
    set_req(2, 1'b1, 3, 1'b1);
    step(g);
    check("single_set", 32'(arr_out), 32'h00000100);
    check("single_id", 32'(wr_id), 32'd2);
    set_req(2, 1'b1, 3, 1'b0);
    step(g);
    check("single_clear", 32'(arr_out), 32'd0);
    set_req(2, 1'b0, 0, 1'b0);

    // Requester 3 out-of-range write moves ptr to 0.
    set_req(3, 1'b1, 15, 1'b0);
    step(g);
    check("oob3_err", 32'(err), 32'd1);
    set_req(3, 1'b0, 0, 1'b0);

    // Out-of-range from requester 0: err pulse, array untouched, ptr -> 1.
    set_req(0, 1'b1, 13, 1'b1);
    step(g);
    check("oob_err", 32'(err), 32'd1);
    check("oob_arr", 32'(arr_out), 32'd0);
    set_req(0, 1'b0, 0, 1'b0);
    step(g);
    check("oob_err_pulse", 32'(err), 32'd0);
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 5, 1'b0);
    step(g);
    check("oob_ptr_adv", 32'(g), 32'd1);
    for (int i = 0; i < NR; i++) set_req(i, (i == 3), 5, 1'b0);
    step(g);
    set_req(3, 1'b0, 0, 1'b0);

    // Same-index conflict from ptr=0: req 1 then req 3, last writer wins.
    set_req(1, 1'b1, 0, 1'b1);
    set_req(3, 1'b1, 0, 1'b0);
    step(g);
    check("conflict_first", 32'(g), 32'd1);
    check("conflict_mid", 32'(arr_out), 32'h00000800);
    set_req(1, 1'b0, 0, 1'b0);
    step(g);
    check("conflict_second", 32'(g), 32'd3);
    check("conflict_final", 32'(arr_out), 32'd0);
    set_req(3, 1'b0, 0, 1'b0);

    // Randomized traffic with holds, withdrawals and occasional clears.
    foreach (pv[i]) pv[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (pv[i]) begin
          if ($urandom_range(9) == 0) pv[i] = 1'b0;
        end else if ($urandom_range(9) < 4) begin
          pv[i]   = 1'b1;
          pidx[i] = $urandom_range((1 << IW) - 1);
          pd[i]   = 1'($urandom_range(1));
        end
        set_req(i, pv[i], pidx[i], pd[i]);
      end
      clr = ($urandom_range(19) == 0);
      step(g);
      if (g >= 0) pv[g] = 1'b0;
    end
    clr = 1'b0;

    // Asynchronous reset mid-cycle, then restart from requester 0.
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, i + 4, 1'b1);
    step(g);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_arr", 32'(arr_out), 32'd0);
    check("async_rst_wv", 32'(wr_valid), 32'd0);
    check("async_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(g);
    check("restart_grant", 32'(g), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
